ccl_union_find: RTL and testbench
=================================

Name: ccl_union_find

Overview:
- First-pass connected-components labeler with exact equivalence resolution, parametrised in label width.
- Per pixel, takes the four previously labelled neighbours A, B, C (row above) and D (left) plus the binary pixel. Emits a provisional label.
- Records every merge as an equivalence pair and links the pairs with a sequential union-find engine.
- At end of frame, flattens the table so a downstream relabel pass can map any provisional label to its root through a read port.

Parameters:
- LABEL_W, 8, label width; labels 1..2^LABEL_W-2 allocatable, 0 = background, 2^LABEL_W-1 = OVF label.
- FIFO_DEPTH, 8, equivalence-pair FIFO entries; must be ≥4 and a power of 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  pixel + neighbours valid
- in_ready  out  1  block accepts pixel this cycle
- sof  in  1  first pixel of frame, qualified by in_valid
- eof  in  1  last pixel of frame, qualified by in_valid
- data  in  1  foreground pixel
- A, B, C, D  in  LABEL_W each  neighbour provisional labels
- q  out  LABEL_W  provisional label
- q_valid  out  1  q valid
- r_addr  in  LABEL_W  resolve-port address
- r_label  out  LABEL_W  table[r_addr], combinational
- num_labels  out  LABEL_W  next label to allocate
- num_components  out  LABEL_W  root count, valid from done
- done  out  1  one-cycle pulse when the table is flattened
- overflow  out  1  sticky; label space exhausted this frame

Behaviour:
- Reset: q=0, q_valid=0, num_labels=1, num_components=0, done=0, overflow=0, FIFO empty, FSM in IDLE. Table contents are not reset.
- Handshake: a pixel is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) && FIFO free slots ≥3.
  - q and q_valid register on the cycle after acceptance (latency 1). q_valid=0 otherwise.
- Accepted pixel with sof: num_labels←1 and overflow←0 before the pixel's own label decision, in the same cycle.
- Label select:
  - data=0 → 0.
  - All neighbours 0 → new label = num_labels; table[num_labels]←num_labels; num_labels+1.
  - Otherwise → m = min of nonzero neighbours.
- Merge: for each distinct nonzero neighbour n≠m, push pair (n,m). Up to 3 pairs are pushed in one cycle.
- Overflow: a new-label request when num_labels == 2^LABEL_W-1 outputs q=OVF, sets overflow, and does not allocate.
  - table[OVF] is written to OVF on every sof.
  - Pairs involving OVF are still pushed.
- Union engine (single FSM, one table access per state per cycle):
  - IDLE: if FIFO non-empty, pop (x,y) → FIND_X. On eof acceptance → DRAIN.
  - FIND_X: if table[x]==x go FIND_Y, else x←table[x].
  - FIND_Y: same walk on y → LINK.
  - LINK: if x≠y, table[max(x,y)]←min(x,y). Return to IDLE, or to DRAIN if draining.
  - DRAIN: pop and process the remaining pairs through the same states; when FIFO is empty and the engine is idle → FLATTEN with i=1.
  - FLATTEN: table[i]←table[table[i]]; increment the root count if table[i]==i; i+1. When i == num_labels-1 is processed → DONE. Ascending order is correct because links always point to a lower index.
  - DONE: assert done for one cycle, latch num_components, go to RESOLVED.
  - RESOLVED: in_ready=1 but only a sof pixel is accepted (non-sof pixels are ignored and dropped). Accepting sof → IDLE processing.
- Simultaneous events:
  - A new-label write to table[num_labels] and a LINK write in the same cycle target different addresses; both take effect.
  - A FIFO push and pop in the same cycle are both allowed.
  - eof on a merge pixel: its pairs enter the FIFO before DRAIN begins.
- r_label is valid only in RESOLVED; in other states it is undefined but must be stable and not X.
- Reset asserted mid-frame or mid-flatten → reset values next cycle; the in-progress frame is abandoned.
- num_labels=1 at eof (no labels): FLATTEN processes nothing, done fires, num_components=0.

Decomposition:
- Shared package additions: LABEL_BG=0, LABEL_OVF(LABEL_W), union-FSM state enum, pair struct {hi,lo}.
- Sub-module: ccl_pair_fifo. Register FIFO, push 0–3 pairs per cycle, pop 1, outputs free_slots and empty.
- Label-select logic stays inline.

Test Plan:
- Single isolated foreground pixel, A–D=0, with sof+eof → q=1, then done, num_components=1, table[1]=1.
- Pixel A=3, C=5, B=D=0, with labels 1..5 allocated → q=3, pair (5,3) pushed; after done, r_addr=5 gives r_label=3.
- Chain merges (4,2), then (6,4), then (2,1) → after flatten r_label is 1 for addrs 2, 4, 6; num_components reflects all remaining roots.
- Three distinct neighbours A=2, C=7, D=5 → one pixel pushes 2 pairs; in_ready drops when free slots <3, and no pairs are lost.
- LABEL_W=3: 7 isolated pixels → labels 1..6, then q=7 with overflow=1; the next sof clears overflow.
- Reset asserted during FLATTEN → next cycle num_labels=1, done=0, in_ready=1; a new frame labels from 1.

Source files
------------

// File: rtl/ccl_union_find_pkg.sv
// Shared types and constants for the connected-components
// labeler and its equivalence-pair FIFO.
package ccl_union_find_pkg;

  localparam int LABEL_BG = 0;
  localparam int PAIR_W_DEF = 8;

  function automatic int label_ovf(input int w);
    return (1 << w) - 1;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIND_X,
    S_FIND_Y,
    S_LINK,
    S_DRAIN,
    S_FLATTEN,
    S_DONE,
    S_RESOLVED
  } uf_state_t;

  typedef struct packed {
    logic [PAIR_W_DEF-1:0] hi;
    logic [PAIR_W_DEF-1:0] lo;
  } pair_t;

endpackage

// File: rtl/ccl_pair_fifo.sv
// Register FIFO of equivalence pairs: up to three pushes
// and one pop per cycle.
module ccl_pair_fifo
  import ccl_union_find_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter type T = pair_t
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             push_cnt,
  input  T [2:0]                 push_data,
  input  logic                   pop,
  output T                       pop_data,
  output logic [$clog2(DEPTH):0] free_slots,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  T mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;

  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign free_slots = (AW+1)'(DEPTH) - count;
  assign pop_data   = mem[rd_ptr];

  // Lay the pushed pairs into consecutive slots
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (k < int'(push_cnt))
        mem[wr_ptr + AW'(k)] <= push_data[k];
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_cnt)
             - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ccl_union_find.sv
// First-pass CCL labeler with a sequential union-find
// engine and end-of-frame table flattening.
module ccl_union_find
  import ccl_union_find_pkg::*;
#(
  parameter int LABEL_W    = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sof,
  input  logic               eof,
  input  logic               data,
  input  logic [LABEL_W-1:0] A,
  input  logic [LABEL_W-1:0] B,
  input  logic [LABEL_W-1:0] C,
  input  logic [LABEL_W-1:0] D,
  output logic [LABEL_W-1:0] q,
  output logic               q_valid,
  input  logic [LABEL_W-1:0] r_addr,
  output logic [LABEL_W-1:0] r_label,
  output logic [LABEL_W-1:0] num_labels,
  output logic [LABEL_W-1:0] num_components,
  output logic               done,
  output logic               overflow
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [LABEL_W-1:0] OVF =
    LABEL_W'(label_ovf(LABEL_W));
  localparam logic [LABEL_W-1:0] BG =
    LABEL_W'(LABEL_BG);
  localparam logic [LABEL_W-1:0] ONE =
    LABEL_W'(1);

  typedef struct packed {
    logic [LABEL_W-1:0] hi;
    logic [LABEL_W-1:0] lo;
  } lpair_t;

  uf_state_t state;
  logic      draining;

  logic [LABEL_W-1:0] tbl [2**LABEL_W];

  logic [LABEL_W-1:0] x, y;
  logic [LABEL_W-1:0] flat_i;
  logic [LABEL_W-1:0] root_cnt;

  logic [LABEL_W-1:0] nb [4];
  logic [LABEL_W-1:0] m;
  logic [LABEL_W-1:0] nl_eff;
  logic               any_nz;
  logic               is_new;
  logic               at_ovf;
  logic               fire;
  logic               accept;
  logic               pop;
  logic               empty;
  logic [1:0]         pair_cnt;
  logic [1:0]         push_cnt;
  lpair_t [2:0]       pairs;
  lpair_t             pop_data;
  logic [FW-1:0]      free;

  logic [LABEL_W-1:0] tx, ty, tf, tff;

  assign tx  = tbl[x];
  assign ty  = tbl[y];
  assign tf  = tbl[flat_i];
  assign tff = tbl[tf];

  assign in_ready =
    (state == S_IDLE && free >= FW'(3)) ||
    (state == S_RESOLVED);

  assign fire   = in_valid && in_ready;
  assign accept = fire && (state != S_RESOLVED || sof);
  assign nl_eff = sof ? ONE : num_labels;
  assign at_ovf = (nl_eff == OVF);
  assign is_new = !any_nz;

  assign push_cnt = (accept && data) ? pair_cnt : 2'd0;

  assign pop = !empty && (
    (state == S_IDLE && !(accept && eof)) ||
    (state == S_DRAIN));

  // Minimum nonzero neighbour and the deduplicated merge pairs
  always_comb begin
    logic dup;
    nb[0]    = A;
    nb[1]    = B;
    nb[2]    = C;
    nb[3]    = D;
    m        = OVF;
    any_nz   = 1'b0;
    pairs    = '0;
    pair_cnt = 2'd0;
    dup      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (nb[k] != BG) begin
        any_nz = 1'b1;
        if (nb[k] < m)
          m = nb[k];
      end
    end
    for (int k = 0; k < 4; k++) begin
      dup = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (j < k && nb[j] == nb[k])
          dup = 1'b1;
      end
      if (nb[k] != BG && nb[k] != m && !dup &&
          pair_cnt != 2'd3) begin
        pairs[pair_cnt] = {nb[k], m};
        pair_cnt = pair_cnt + 2'd1;
      end
    end
  end

  ccl_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (lpair_t)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_cnt   (push_cnt),
    .push_data  (pairs),
    .pop        (pop),
    .pop_data   (pop_data),
    .free_slots (free),
    .empty      (empty)
  );

  // Resolve port: only allocated entries are read from the table
  always_comb begin
    r_label = BG;
    if (state == S_RESOLVED) begin
      if (r_addr == OVF)
        r_label = OVF;
      else if (r_addr != BG && r_addr < num_labels)
        r_label = tbl[r_addr];
    end
  end

  // Provisional label output and label allocation
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q          <= BG;
      q_valid    <= 1'b0;
      num_labels <= ONE;
      overflow   <= 1'b0;
    end else begin
      q_valid <= accept;
      if (accept) begin
        if (sof) begin
          num_labels <= ONE;
          overflow   <= 1'b0;
        end
        if (!data) begin
          q <= BG;
        end else if (!is_new) begin
          q <= m;
        end else if (at_ovf) begin
          q        <= OVF;
          overflow <= 1'b1;
        end else begin
          q          <= nl_eff;
          num_labels <= nl_eff + ONE;
        end
      end
    end
  end

  // Equivalence table writes from labeling, linking, flattening
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (accept && sof)
        tbl[OVF] <= OVF;
      if (accept && data && is_new && !at_ovf)
        tbl[nl_eff] <= nl_eff;
      if (state == S_LINK && x != y) begin
        if (x > y)
          tbl[x] <= y;
        else
          tbl[y] <= x;
      end
      if (state == S_FLATTEN)
        tbl[flat_i] <= tff;
    end
  end

  // Union-find engine and end-of-frame sequencing
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      draining       <= 1'b0;
      x              <= BG;
      y              <= BG;
      flat_i         <= ONE;
      root_cnt       <= BG;
      num_components <= BG;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && eof) begin
            state    <= S_DRAIN;
            draining <= 1'b1;
          end else if (pop) begin
            x     <= pop_data.hi;
            y     <= pop_data.lo;
            state <= S_FIND_X;
          end
        end
        S_FIND_X: begin
          if (tx == x)
            state <= S_FIND_Y;
          else
            x <= tx;
        end
        S_FIND_Y: begin
          if (ty == y)
            state <= S_LINK;
          else
            y <= ty;
        end
        S_LINK: begin
          state <= draining ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: begin
          root_cnt <= BG;
          flat_i   <= ONE;
          if (pop) begin
            x     <= pop_data.hi;
            y     <= pop_data.lo;
            state <= S_FIND_X;
          end else if (num_labels <= ONE) begin
            state <= S_DONE;
          end else begin
            state <= S_FLATTEN;
          end
        end
        S_FLATTEN: begin
          if (tf == flat_i)
            root_cnt <= root_cnt + ONE;
          flat_i <= flat_i + ONE;
          if (flat_i == num_labels - ONE)
            state <= S_DONE;
        end
        S_DONE: begin
          done           <= 1'b1;
          num_components <= root_cnt;
          draining       <= 1'b0;
          state          <= S_RESOLVED;
        end
        S_RESOLVED: begin
          if (accept) begin
            if (eof) begin
              state    <= S_DRAIN;
              draining <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccl_union_find.sv
// Testbench for ccl_union_find: vector table, scoreboard
// on q, and frame-level resolve checks.
module tb_ccl_union_find;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, sof, eof, data;
  logic [7:0] A, B, C, D, r_addr;
  logic       in_ready, q_valid, done, overflow;
  logic [7:0] q, r_label, num_labels, num_components;

  logic       in_valid3, sof3, eof3, data3;
  logic [2:0] A3, B3, C3, D3, r_addr3;
  logic       in_ready3, q_valid3, done3, overflow3;
  logic [2:0] q3, r_label3, num_labels3, num_components3;

  int tests = 0;
  int fails = 0;

  logic [7:0] expq[$];
  logic [2:0] expq3[$];

  typedef struct {
    logic       s, e, d;
    logic [7:0] a, b, c, dd, q;
  } vec_t;

  vec_t vt[15];

  always #5 clk = ~clk;

  ccl_union_find #(.LABEL_W(8), .FIFO_DEPTH(8)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sof(sof), .eof(eof), .data(data),
    .A(A), .B(B), .C(C), .D(D),
    .q(q), .q_valid(q_valid),
    .r_addr(r_addr), .r_label(r_label),
    .num_labels(num_labels),
    .num_components(num_components),
    .done(done), .overflow(overflow)
  );

  ccl_union_find #(.LABEL_W(3), .FIFO_DEPTH(8)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .sof(sof3), .eof(eof3), .data(data3),
    .A(A3), .B(B3), .C(C3), .D(D3),
    .q(q3), .q_valid(q_valid3),
    .r_addr(r_addr3), .r_label(r_label3),
    .num_labels(num_labels3),
    .num_components(num_components3),
    .done(done3), .overflow(overflow3)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Scoreboard for the 8-bit instance
  always @(negedge clk) begin
    if (reset_n === 1'b1 && q_valid === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL q_unexpected: got %0d expected none", q);
      end else begin
        chk("q", 32'(q), 32'(expq.pop_front()));
      end
    end
  end

  // Scoreboard for the 3-bit instance
  always @(negedge clk) begin
    if (reset_n === 1'b1 && q_valid3 === 1'b1) begin
      if (expq3.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL q3_unexpected: got %0d expected none", q3);
      end else begin
        chk("q3", 32'(q3), 32'(expq3.pop_front()));
      end
    end
  end

  task automatic send(input logic s, e, dv,
                      input logic [7:0] pa, pb, pc, pd,
                      input logic [7:0] exp,
                      input bit has_exp);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
      return;
    end
    sof = s; eof = e; data = dv;
    A = pa; B = pb; C = pc; D = pd;
    in_valid = 1'b1;
    if (has_exp) expq.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  task automatic send3(input logic s, e,
                       input logic [2:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready3 !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (in_ready3 !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send3_timeout: got in_ready=0 expected 1");
      return;
    end
    sof3 = s; eof3 = e; data3 = 1'b1;
    in_valid3 = 1'b1;
    expq3.push_back(exp);
    @(posedge clk);
    #1;
    in_valid3 = 1'b0; sof3 = 1'b0; eof3 = 1'b0;
  endtask

  task automatic wait_done(input string name,
                           input logic [7:0] ncomp);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 32'(done), 32'(1));
    chk({name, "_ncomp"}, 32'(num_components), 32'(ncomp));
  endtask

  task automatic chk_r(input logic [7:0] addr,
                       input logic [7:0] exp);
    @(negedge clk);
    r_addr = addr;
    #1;
    chk($sformatf("r_label[%0d]", addr),
        32'(r_label), 32'(exp));
  endtask

  function automatic vec_t mk(input logic s, e, d,
                              input logic [7:0] a, b, c, dd, qq);
    vec_t v;
    v.s = s; v.e = e; v.d = d;
    v.a = a; v.b = b; v.c = c; v.dd = dd; v.q = qq;
    return v;
  endfunction

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; sof = 1'b0; eof = 1'b0; data = 1'b0;
    A = 8'd0; B = 8'd0; C = 8'd0; D = 8'd0; r_addr = 8'd0;
    in_valid3 = 1'b0; sof3 = 1'b0; eof3 = 1'b0; data3 = 1'b0;
    A3 = 3'd0; B3 = 3'd0; C3 = 3'd0; D3 = 3'd0; r_addr3 = 3'd0;

    vt[0]  = mk(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1);
    vt[1]  = mk(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2);
    vt[2]  = mk(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3);
    vt[3]  = mk(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd4);
    vt[4]  = mk(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5);
    vt[5]  = mk(1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    vt[6]  = mk(1'b0, 1'b0, 1'b1, 8'd3, 8'd0, 8'd5, 8'd0, 8'd3);
    vt[7]  = mk(1'b0, 1'b0, 1'b1, 8'd4, 8'd2, 8'd0, 8'd0, 8'd2);
    vt[8]  = mk(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6);
    vt[9]  = mk(1'b0, 1'b0, 1'b1, 8'd6, 8'd4, 8'd0, 8'd0, 8'd4);
    vt[10] = mk(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd2, 8'd1, 8'd1);
    vt[11] = mk(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7);
    vt[12] = mk(1'b0, 1'b0, 1'b1, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3);
    vt[13] = mk(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8);
    vt[14] = mk(1'b0, 1'b1, 1'b1, 8'd7, 8'd0, 8'd8, 8'd0, 8'd7);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_q_valid", 32'(q_valid), 32'(0));
    chk("rst_num_labels", 32'(num_labels), 32'(1));
    chk("rst_num_comp", 32'(num_components), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_r_label_known", 32'($isunknown(r_label)), 32'(0));

    // Single isolated pixel frame
    send(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 1'b1);
    wait_done("single", 8'd1);
    chk_r(8'd1, 8'd1);
    chk("single_num_labels", 32'(num_labels), 32'(2));

    // Table-driven frame: chain merges and an eof merge pixel
    for (int i = 0; i < 15; i++)
      send(vt[i].s, vt[i].e, vt[i].d,
           vt[i].a, vt[i].b, vt[i].c, vt[i].dd,
           vt[i].q, 1'b1);
    wait_done("chain", 8'd3);
    chk("chain_num_labels", 32'(num_labels), 32'(9));
    chk_r(8'd1, 8'd1);
    chk_r(8'd2, 8'd1);
    chk_r(8'd3, 8'd3);
    chk_r(8'd4, 8'd1);
    chk_r(8'd5, 8'd3);
    chk_r(8'd6, 8'd1);
    chk_r(8'd7, 8'd7);
    chk_r(8'd8, 8'd7);

    // Non-sof pixel after done is dropped
    send(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    chk("drop_q_valid", 32'(q_valid), 32'(0));
    chk("drop_num_labels", 32'(num_labels), 32'(9));
    chk_r(8'd5, 8'd3);

    // Multi-pair pixels that stress the FIFO
    for (int i = 1; i <= 7; i++)
      send(i == 1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0,
           8'(i), 1'b1);
    send(1'b0, 1'b0, 1'b1, 8'd2, 8'd2, 8'd7, 8'd5, 8'd2, 1'b1);
    send(1'b0, 1'b0, 1'b1, 8'd3, 8'd4, 8'd6, 8'd0, 8'd3, 1'b1);
    send(1'b0, 1'b1, 1'b1, 8'd1, 8'd6, 8'd4, 8'd7, 8'd1, 1'b1);
    wait_done("burst", 8'd1);
    for (int i = 2; i <= 7; i++)
      chk_r(8'(i), 8'd1);

    // Frame without any foreground
    send(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    wait_done("empty", 8'd0);
    chk("empty_num_labels", 32'(num_labels), 32'(1));

    // Reset in the middle of flattening
    for (int i = 1; i <= 20; i++)
      send(i == 1, i == 20, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0,
           8'(i), 1'b1);
    repeat (3) @(negedge clk);
    chk("flat_not_done", 32'(done), 32'(0));
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_num_labels", 32'(num_labels), 32'(1));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    chk("mid_rst_overflow", 32'(overflow), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    send(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 1'b1);
    wait_done("post_rst", 8'd1);
    chk_r(8'd1, 8'd1);

    // Label-space exhaustion on the 3-bit instance
    for (int i = 1; i <= 6; i++)
      send3(i == 1, 1'b0, 3'(i));
    chk("ovf_before", 32'(overflow3), 32'(0));
    send3(1'b0, 1'b0, 3'd7);
    chk("ovf_set", 32'(overflow3), 32'(1));
    chk("ovf_num_labels", 32'(num_labels3), 32'(7));
    send3(1'b0, 1'b0, 3'd7);
    chk("ovf_hold", 32'(num_labels3), 32'(7));
    send3(1'b1, 1'b0, 3'd1);
    chk("ovf_cleared", 32'(overflow3), 32'(0));
    send3(1'b0, 1'b1, 3'd2);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (done3 !== 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("ovf_done", 32'(done3), 32'(1));
      chk("ovf_ncomp", 32'(num_components3), 32'(2));
    end

    repeat (3) @(negedge clk);
    chk("q_left", 32'(expq.size()), 32'(0));
    chk("q3_left", 32'(expq3.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
